// File: rtl/tpu_pkg.sv
// Shared opcode, state and control-word definitions for the TPU instruction sequencer.
package tpu_pkg;

    typedef enum logic [2:0] {
        OpRhm  = 3'd0,
        OpLw   = 3'd1,
        OpLs   = 3'd2,
        OpMm   = 3'd3,
        OpWhm  = 3'd4,
        OpNop  = 3'd5,
        OpIll6 = 3'd6,
        OpIll7 = 3'd7
    } opcode_t;

    typedef logic [3:0] state_t;

    localparam state_t StIdle       = 4'd0;
    localparam state_t StDecode     = 4'd1;
    localparam state_t StRhm        = 4'd2;
    localparam state_t StLw         = 4'd3;
    localparam state_t StLwWait     = 4'd4;
    localparam state_t StLs         = 4'd5;
    localparam state_t StLsWait     = 4'd6;
    localparam state_t StResultWait = 4'd7;
    localparam state_t StMmResult   = 4'd8;
    localparam state_t StWhm        = 4'd9;

    localparam logic [11:0] CtrlIdle       = 12'h000;
    localparam logic [11:0] CtrlRhm        = 12'h580;
    localparam logic [11:0] CtrlLw         = 12'h240;
    localparam logic [11:0] CtrlLwWait     = 12'h020;
    localparam logic [11:0] CtrlLs         = 12'h210;
    localparam logic [11:0] CtrlLsWait     = 12'h00C;
    localparam logic [11:0] CtrlResultWait = 12'h00D;
    localparam logic [11:0] CtrlMmResult   = 12'h182;
    localparam logic [11:0] CtrlWhm        = 12'hA00;

    function automatic logic [11:0] ctrl_for_state(state_t s);
        case (s)
            StRhm:        return CtrlRhm;
            StLw:         return CtrlLw;
            StLwWait:     return CtrlLwWait;
            StLs:         return CtrlLs;
            StLsWait:     return CtrlLsWait;
            StResultWait: return CtrlResultWait;
            StMmResult:   return CtrlMmResult;
            StWhm:        return CtrlWhm;
            default:      return CtrlIdle;
        endcase
    endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Host instruction push handshake: opcode in [AW+2:AW], address in [AW-1:0].
interface tpu_sequencer_if #(
    parameter int unsigned AW = 3
);
    logic          instr_valid;
    logic [AW+2:0] instr_data;
    logic          instr_ready;

    modport master (output instr_valid, output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/tpu_instr_fifo.sv
// Instruction queue: power-of-two ring buffer with synchronous flush that wins over push/pop.
module tpu_instr_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullLevel = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      level_q;
    logic             do_push, do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = (level_q == FullLevel);
    assign empty = (level_q == '0);
    assign level = level_q;
endmodule

// File: rtl/tpu_sequencer.sv
// TPU instruction sequencer: queues host instructions and steps the datapath control word.
// Define TPU_SEQ_PERF_EN to build the saturating MM-count and busy-cycle counters.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned K      = 8,
    parameter int unsigned QDEPTH = 4,
    localparam int unsigned AW    = $clog2(K),
    localparam int unsigned QW    = $clog2(QDEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tpu_sequencer_if.slave        host,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [11:0]           ctrl,
    output logic [AW-1:0]         instr_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err_illegal,
    output logic [QW-1:0]         q_level,
    output logic [31:0]           perf_mm_cnt,
    output logic [31:0]           perf_busy_cyc
);
    localparam int unsigned IW = AW + 3;
    localparam int unsigned CW = $clog2(2 * N) + 1;
    localparam logic [CW-1:0] WaitN  = CW'(N - 1);
    localparam logic [CW-1:0] Wait2N = CW'(2 * N - 1);

    logic [IW-1:0] head;
    logic          fifo_full, fifo_empty, pop;
    state_t        state_q, state_d;
    opcode_t       op_q;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, err_q, err_d;

    // A flush in the same cycle suppresses the pop so nothing stale starts executing.
    assign pop              = (state_q == StIdle) && !fifo_empty && !flush;
    assign host.instr_ready = !fifo_full;

    tpu_instr_fifo #(
        .WIDTH(IW),
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.instr_valid),
        .pop   (pop),
        .flush (flush),
        .din   (host.instr_data),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (q_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q && !err_clr;
        case (state_q)
            StIdle: if (pop) state_d = StDecode;
            StDecode: begin
                case (op_q)
                    OpRhm: state_d = StRhm;
                    OpLw:  state_d = StLw;
                    OpLs:  state_d = StLs;
                    OpWhm: state_d = StWhm;
                    OpMm: begin
                        state_d = StLsWait;
                        cnt_d   = WaitN;
                    end
                    OpNop: begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                endcase
            end
            StRhm, StLs, StWhm, StMmResult: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            StLw: begin
                state_d = StLwWait;
                cnt_d   = WaitN;
            end
            StLwWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLsWait: begin
                if (cnt_q == '0) begin
                    state_d = StResultWait;
                    cnt_d   = Wait2N;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResultWait: begin
                if (cnt_q == '0) state_d = StMmResult;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpRhm;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (pop) begin
                op_q   <= opcode_t'(head[IW-1:AW]);
                addr_q <= head[AW-1:0];
            end
        end
    end

    assign ctrl        = ctrl_for_state(state_q);
    assign busy        = (state_q != StIdle);
    assign instr_addr  = busy ? addr_q : '0;
    assign done        = done_q;
    assign err_illegal = err_q;

`ifdef TPU_SEQ_PERF_EN
    logic [31:0] mm_cnt_q, busy_cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_cnt_q   <= '0;
            busy_cyc_q <= '0;
        end else begin
            if (state_d == StMmResult && state_q != StMmResult && mm_cnt_q != '1) begin
                mm_cnt_q <= mm_cnt_q + 32'd1;
            end
            if (busy && busy_cyc_q != '1) busy_cyc_q <= busy_cyc_q + 32'd1;
        end
    end

    assign perf_mm_cnt   = mm_cnt_q;
    assign perf_busy_cyc = busy_cyc_q;
`else
    assign perf_mm_cnt   = '0;
    assign perf_busy_cyc = '0;
`endif
endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer against a queue/trace-level reference model.
module tb_tpu_sequencer;
    localparam int unsigned N  = 4;
    localparam int unsigned K  = 8;
    localparam int unsigned QD = 4;
    localparam int unsigned AW = 3;
`ifdef TPU_SEQ_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          err_clr = 1'b0;
    logic [11:0]   ctrl;
    logic [AW-1:0] instr_addr;
    logic          busy, done, err_illegal;
    logic [2:0]    q_level;
    logic [31:0]   perf_mm_cnt, perf_busy_cyc;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_lwwait = 0;

    tpu_sequencer_if #(.AW(AW)) host ();

    tpu_sequencer #(
        .N(N),
        .K(K),
        .QDEPTH(QD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (host),
        .flush         (flush),
        .err_clr       (err_clr),
        .ctrl          (ctrl),
        .instr_addr    (instr_addr),
        .busy          (busy),
        .done          (done),
        .err_illegal   (err_illegal),
        .q_level       (q_level),
        .perf_mm_cnt   (perf_mm_cnt),
        .perf_busy_cyc (perf_busy_cyc)
    );

    always #5 clk = ~clk;

    // Reference model: pending instructions plus the remaining per-cycle ctrl trace of the
    // executing one (empty trace means idle).
    logic [5:0]    mq[$];
    logic [11:0]   trace[$];
    logic [AW-1:0] m_addr = '0;
    bit            m_legal = 1'b0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;
    int            m_mm = 0;
    int            m_busy = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_trace(input logic [5:0] ins);
        logic [2:0] op;
        op      = ins[5:3];
        m_addr  = ins[2:0];
        m_legal = (op <= 3'd5);
        trace.delete();
        trace.push_back(12'h000);
        case (op)
            3'd0: trace.push_back(12'h580);
            3'd1: begin
                trace.push_back(12'h240);
                repeat (N) trace.push_back(12'h020);
            end
            3'd2: trace.push_back(12'h210);
            3'd3: begin
                repeat (N) trace.push_back(12'h00C);
                repeat (2 * N) trace.push_back(12'h00D);
                trace.push_back(12'h182);
            end
            3'd4: trace.push_back(12'hA00);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        mq.delete();
        trace.delete();
        m_addr = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_mm   = 0;
        m_busy = 0;
    endtask

    task automatic model_step();
        bit idle, do_pop, do_push;
        idle    = (trace.size() == 0);
        do_pop  = idle && (mq.size() > 0) && !flush;
        do_push = host.instr_valid && (mq.size() < QD) && !flush;
        if (!idle) m_busy++;
        m_done = (trace.size() == 1) && m_legal;
        if (trace.size() == 1 && !m_legal) m_err = 1'b1;
        else if (err_clr)                  m_err = 1'b0;
        if (!idle) void'(trace.pop_front());
        if (do_pop) load_trace(mq.pop_front());
        if (flush)        mq.delete();
        else if (do_push) mq.push_back(host.instr_data);
        if (trace.size() != 0 && trace[0] == 12'h182) m_mm++;
    endtask

    task automatic compare_all(input string tag);
        logic [11:0] ec;
        bit          eb;
        eb = (trace.size() != 0);
        ec = eb ? trace[0] : 12'h000;
        check({tag, ".ctrl"},  32'(ctrl), 32'(ec));
        check({tag, ".busy"},  32'(busy), 32'(eb));
        check({tag, ".addr"},  32'(instr_addr), eb ? 32'(m_addr) : 32'd0);
        check({tag, ".done"},  32'(done), 32'(m_done));
        check({tag, ".err"},   32'(err_illegal), 32'(m_err));
        check({tag, ".level"}, 32'(q_level), 32'(mq.size()));
        check({tag, ".ready"}, 32'(host.instr_ready), 32'(mq.size() < QD));
        check({tag, ".pmm"},   perf_mm_cnt, PerfEn ? 32'(m_mm) : 32'd0);
        check({tag, ".pbusy"}, perf_busy_cyc, PerfEn ? 32'(m_busy) : 32'd0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
        if (done) n_done++;
        if (ctrl == 12'h020) n_lwwait++;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        @(posedge clk);
        #1;
        compare_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] addr, input string tag);
        bit acc;
        acc = 1'b0;
        host.instr_valid = 1'b1;
        host.instr_data  = {op, addr};
        for (int i = 0; i < 100 && !acc; i++) begin
            acc = (mq.size() < QD);
            tick(tag);
        end
        host.instr_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $error("FAIL %s.accept observed=timeout expected=accepted", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (trace.size() != 0 || mq.size() != 0); i++) tick(tag);
        checks++;
        if (trace.size() != 0 || mq.size() != 0) begin
            errors++;
            $error("FAIL %s.idle observed=timeout expected=idle", tag);
        end
        tick(tag);
    endtask

    task automatic wait_front(input logic [11:0] val, input string tag);
        for (int i = 0; i < 100 && !(trace.size() != 0 && trace[0] == val); i++) tick(tag);
        checks++;
        if (!(trace.size() != 0 && trace[0] == val)) begin
            errors++;
            $error("FAIL %s.front observed=timeout expected=%0h", tag, val);
        end
    endtask

    initial begin
        int nc, nd, nr, nm, d0, l0;
        logic [AW-1:0] raddr;
        host.instr_valid = 1'b0;
        host.instr_data  = '0;
        do_reset("reset");
        check("reset.ready", 32'(host.instr_ready), 32'd1);

        // Single MM at address 3: count the wait-state cycles straight off the DUT.
        send(3'd3, 3'd3, "mm");
        nc = 0; nd = 0; nr = 0; nm = 0; raddr = '0;
        tick("mm.pre");
        check("mm.decode_busy", 32'(busy), 32'd1);
        check("mm.decode_ctrl", 32'(ctrl), 32'h000);
        for (int i = 0; i < 18; i++) begin
            tick("mm.run");
            if (ctrl == 12'h00C) nc++;
            if (ctrl == 12'h00D) nd++;
            if (ctrl == 12'h182) begin nr++; raddr = instr_addr; end
            if (done) nm++;
        end
        check("mm.ls_wait_cycles", 32'(nc), 32'd4);
        check("mm.result_wait_cycles", 32'(nd), 32'd8);
        check("mm.mm_result_cycles", 32'(nr), 32'd1);
        check("mm.result_addr", 32'(raddr), 32'd3);
        check("mm.done_pulses", 32'(nm), 32'd1);

        // Five LW pushed behind a busy MM: queue fills after the fourth.
        send(3'd3, 3'd7, "lw.mm");
        l0 = n_lwwait;
        for (int i = 0; i < 4; i++) send(3'd1, 3'(i), "lw.push");
        check("lw.full_level", 32'(q_level), 32'd4);
        check("lw.full_ready", 32'(host.instr_ready), 32'd0);
        send(3'd1, 3'd4, "lw.push5");
        wait_idle("lw.drain");
        check("lw.wait_cycles", 32'(n_lwwait - l0), 32'd20);

        // Illegal opcode then NOP.
        d0 = n_done;
        send(3'd7, 3'd1, "ill");
        send(3'd5, 3'd2, "ill.nop");
        wait_idle("ill.drain");
        check("ill.err_set", 32'(err_illegal), 32'd1);
        check("ill.done_count", 32'(n_done - d0), 32'd1);
        err_clr = 1'b1;
        tick("ill.clr");
        err_clr = 1'b0;
        check("ill.err_cleared", 32'(err_illegal), 32'd0);

        // Flush with three queued during LW_WAIT.
        d0 = n_done;
        send(3'd1, 3'd5, "fl.lw");
        send(3'd0, 3'd1, "fl.q1");
        send(3'd2, 3'd2, "fl.q2");
        send(3'd4, 3'd3, "fl.q3");
        wait_front(12'h020, "fl.wait");
        check("fl.level_before", 32'(q_level), 32'd3);
        flush = 1'b1;
        tick("fl.flush");
        flush = 1'b0;
        check("fl.level_after", 32'(q_level), 32'd0);
        wait_idle("fl.drain");
        repeat (3) tick("fl.after");
        check("fl.done_count", 32'(n_done - d0), 32'd1);
        check("fl.stays_idle", 32'(busy), 32'd0);

        // Asynchronous reset in RESULT_WAIT with a queued instruction.
        send(3'd3, 3'd6, "rst.mm");
        send(3'd0, 3'd0, "rst.q");
        wait_front(12'h00D, "rst.wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.ctrl", 32'(ctrl), 32'h000);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.level", 32'(q_level), 32'd0);
        check("rst.ready", 32'(host.instr_ready), 32'd1);
        do_reset("rst");
        send(3'd0, 3'd4, "rst.rhm");
        wait_front(12'h580, "rst.rhm_wait");
        check("rst.rhm_ctrl", 32'(ctrl), 32'h580);
        wait_idle("rst.rhm_drain");

        // Two MM for the performance counters.
        do_reset("perf");
        send(3'd3, 3'd1, "perf.mm1");
        send(3'd3, 3'd2, "perf.mm2");
        wait_idle("perf.drain");
        check("perf.mm_cnt", perf_mm_cnt, PerfEn ? 32'd2 : 32'd0);
        check("perf.busy_cyc", perf_busy_cyc, PerfEn ? 32'd28 : 32'd0);

        // Randomized traffic, flushes and error clears against the model.
        for (int i = 0; i < 500; i++) begin
            host.instr_valid = ($urandom_range(0, 2) != 0);
            host.instr_data  = 6'($urandom_range(0, 63));
            flush            = ($urandom_range(0, 19) == 0);
            err_clr          = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        host.instr_valid = 1'b0;
        flush            = 1'b0;
        err_clr          = 1'b0;
        wait_idle("rand.drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_sequencer.md
TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension; sets all wait-state lengths.
REQ-002 SHALL have parameter K, default 8: host-memory row count; AW = $clog2(K).
REQ-003 SHALL have parameter QDEPTH, default 4: instruction queue depth, power of 2, ≥2.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port instr_valid  in  1  host offers an instruction.
REQ-007 SHALL have port instr_data  in  3+AW  opcode in [AW+2:AW], address in [AW-1:0].
REQ-008 SHALL have port instr_ready  out  1  queue can accept; equals !full.
REQ-009 SHALL have port flush  in  1  synchronous discard of all queued, not-yet-popped instructions.
REQ-010 SHALL have port err_clr  in  1  clears err_illegal.
REQ-011 SHALL have port ctrl  out  12  datapath control word.
REQ-012 SHALL have port instr_addr  out  AW  address field of the executing instruction.
REQ-013 SHALL have port busy  out  1  FSM not in IDLE.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port err_illegal  out  1  sticky illegal-opcode flag.
REQ-016 SHALL have port q_level  out  $clog2(QDEPTH)+1  current queue occupancy.
REQ-017 SHALL have ports perf_mm_cnt and perf_busy_cyc  out  32 each  performance counters (see Configuration).

Function
REQ-018 SHALL accept an instruction on any clk edge where instr_valid && instr_ready; a push while full is impossible because instr_ready is low.
REQ-019 SHALL pop the queue head when in IDLE with q_level>0, latch it, and enter DECODE on the next cycle; there is no empty-queue bypass.
REQ-020 SHALL decode opcodes as 0 RHM, 1 LW, 2 LS, 3 MM, 4 WHM, 5 NOP, 6-7 illegal.
REQ-021 SHALL sequence as follows: RHM, LS, WHM each 1 cycle then IDLE; LW 1 cycle, then LW_WAIT exactly N cycles, then IDLE; MM goes LS_WAIT N cycles, RESULT_WAIT 2N cycles, MM_RESULT 1 cycle, then IDLE; NOP goes DECODE→IDLE.
REQ-022 SHALL drive ctrl per state as IDLE/DECODE 000, RHM 580, LW 240, LW_WAIT 020, LS 210, LS_WAIT 00C, RESULT_WAIT 00D, MM_RESULT 182, WHM A00 (hex).
REQ-023 SHALL hold instr_addr stable from DECODE until IDLE and drive 0 in IDLE.
REQ-024 SHALL register done high for exactly the first IDLE cycle after any legal instruction, NOP included.
REQ-025 SHALL, on an illegal opcode, return DECODE→IDLE, set err_illegal, and not pulse done.
REQ-026 SHALL keep err_illegal set until err_clr; when err_clr and a new illegal opcode coincide, set wins.
REQ-027 SHALL, on flush, empty the queue next cycle; an executing instruction completes normally; flush wins over a same-cycle push or pop.
REQ-028 SHALL wrap the queue pointers modulo QDEPTH; a simultaneous push and pop leaves q_level unchanged.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-operation, immediately set FSM=IDLE, queue empty, wait counter 0, ctrl=0, instr_addr=0, busy=0, done=0, err_illegal=0, and perf counters 0.
REQ-030 SHALL leave instr_ready=1 while reset is asserted and afterwards.

Configuration
REQ-031 SHALL, when TPU_SEQ_PERF_EN is defined, make perf_mm_cnt increment on each MM_RESULT entry and perf_busy_cyc increment on each busy cycle; both saturate at all-ones.
REQ-032 SHALL, when TPU_SEQ_PERF_EN is undefined, tie both perf ports to 0 and remove the counter logic.

Structure
REQ-033 SHALL place opcode_t, state_t, and the ctrl-word localparams in shared package tpu_pkg.
REQ-034 SHALL implement the queue as sub-module tpu_instr_fifo (parameters WIDTH, DEPTH; push/pop/flush/full/empty/level).

Verification (N=4, K=8, QDEPTH=4)
REQ-035 SHALL cover: push MM addr 3 into empty queue → DECODE 2 cycles after push, ctrl=00C for 4 cycles, then 00D for 8 cycles, then 182 for 1 cycle with instr_addr=3, then done for 1 cycle.
REQ-036 SHALL cover: push 5 LW with the FSM busy → instr_ready low after the 4th; q_level=4; all 5 execute in order, each with 4 LW_WAIT cycles.
REQ-037 SHALL cover: push opcode 7, then NOP → err_illegal=1, no done for the first, done for the NOP; err_clr clears the flag.
REQ-038 SHALL cover: 3 queued, flush during LW_WAIT → q_level=0 next cycle, LW finishes with done, FSM stays IDLE.
REQ-039 SHALL cover: rst_n low in RESULT_WAIT → ctrl=0, busy=0, q_level=0 asynchronously; a post-reset RHM produces ctrl=580.
REQ-040 SHALL cover, with TPU_SEQ_PERF_EN defined: 2 MM → perf_mm_cnt=2, perf_busy_cyc=28.
